// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq block: operation select encoding,
// controller state encoding and a helper that flags unused select codes.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SRL = 4'b0110,
        OP_SRA = 4'b0111,
        OP_MUL = 4'b1000
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Codes above MUL carry no operation.
    function automatic logic is_reserved(input logic [3:0] sel);
        return (sel > 4'b1000);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier datapath, one partial product per step.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a/b and clear the accumulator
//   step       : perform one shift-add iteration
//   a, b       : N-bit unsigned operands
//   prod_next  : accumulator value after the current iteration (combinational)
//   last       : the current step is the final (N-th) iteration
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod_next,
    output logic           last
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [2*N-1:0] mcand_r;
    logic [N-1:0]   mplier_r;
    logic [2*N-1:0] prod_r;
    logic [CW-1:0]  cnt_r;

    // The final iteration's sum is exposed so the controller can register the
    // product on the same edge that completes it, without an extra cycle.
    assign prod_next = prod_r + (mplier_r[0] ? mcand_r : {(2*N){1'b0}});
    assign last      = (cnt_r == LAST_CNT);

    // Operand/accumulator registers: load clears, each step shifts and adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*N){1'b0}};
            mplier_r <= {N{1'b0}};
            prod_r   <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (load) begin
            mcand_r  <= {{N{1'b0}}, a};
            mplier_r <= b;
            prod_r   <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (step) begin
            prod_r   <= prod_next;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops and an N-cycle
// shift-add unsigned multiply, with registered result, flags and error.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, taken when busy=0
//   A, B, sel      : operands and operation select (B low bits = shift amount)
//   out            : registered result
//   Z, Neg, Ca, O  : registered zero, negative, carry, signed-overflow flags
//   busy           : multiply in progress
//   done           : one-cycle pulse when out/flags update
//   err            : registered, set when the completed op used a reserved sel
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   sel,
    output logic [N-1:0] out,
    output logic         Z,
    output logic         Neg,
    output logic         Ca,
    output logic         O,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int SW = $clog2(N);

    state_e         state_r, state_nxt_s;
    logic [N-1:0]   out_r;
    logic           z_r, neg_r, ca_r, o_r, done_r, err_r;

    logic [SW-1:0]  sh_s;
    logic [N:0]     add_w_s, sub_w_s;
    logic [2*N-1:0] sll_w_s, srl_w_s, sra_w_s;

    logic [N-1:0]   alu_res_s;
    logic           alu_ca_s, alu_ov_s, alu_err_s;

    logic           load_s, step_s, upd_s;
    logic [N-1:0]   res_nxt_s;
    logic           ca_nxt_s, ov_nxt_s, err_nxt_s;

    logic [2*N-1:0] prod_next_s;
    logic           mul_last_s;

    assign sh_s    = B[SW-1:0];
    assign add_w_s = {1'b0, A} + {1'b0, B};
    assign sub_w_s = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
    // Shifting inside a double-width word keeps the last bit shifted out at a
    // fixed position (bit N for left, bit N-1 for right shifts).
    assign sll_w_s = {{N{1'b0}}, A} << sh_s;
    assign srl_w_s = {A, {N{1'b0}}} >> sh_s;
    assign sra_w_s = $signed({A, {N{1'b0}}}) >>> sh_s;

    // Single-cycle operation results and flags.
    always_comb begin
        alu_res_s = {N{1'b0}};
        alu_ca_s  = 1'b0;
        alu_ov_s  = 1'b0;
        alu_err_s = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_res_s = add_w_s[N-1:0];
                alu_ca_s  = add_w_s[N];
                alu_ov_s  = (A[N-1] == B[N-1]) && (add_w_s[N-1] != A[N-1]);
            end
            OP_SUB: begin
                alu_res_s = sub_w_s[N-1:0];
                alu_ca_s  = sub_w_s[N];
                alu_ov_s  = (A[N-1] != B[N-1]) && (sub_w_s[N-1] != A[N-1]);
            end
            OP_AND: alu_res_s = A & B;
            OP_OR:  alu_res_s = A | B;
            OP_XOR: alu_res_s = A ^ B;
            OP_SLL: begin
                alu_res_s = sll_w_s[N-1:0];
                alu_ca_s  = (sh_s != {SW{1'b0}}) ? sll_w_s[N] : 1'b0;
            end
            OP_SRL: begin
                alu_res_s = srl_w_s[2*N-1:N];
                alu_ca_s  = (sh_s != {SW{1'b0}}) ? srl_w_s[N-1] : 1'b0;
            end
            OP_SRA: begin
                alu_res_s = sra_w_s[2*N-1:N];
                alu_ca_s  = (sh_s != {SW{1'b0}}) ? sra_w_s[N-1] : 1'b0;
            end
            default: begin
                alu_err_s = is_reserved(sel);
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, multiplier control and the value to publish on completion.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        upd_s       = 1'b0;
        res_nxt_s   = alu_res_s;
        ca_nxt_s    = alu_ca_s;
        ov_nxt_s    = alu_ov_s;
        err_nxt_s   = alu_err_s;
        case (state_r)
            ST_IDLE: begin
                if (start && (sel == OP_MUL)) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_MUL;
                end else if (start) begin
                    upd_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                step_s = 1'b1;
                if (mul_last_s) begin
                    state_nxt_s = ST_IDLE;
                    upd_s       = 1'b1;
                    res_nxt_s   = prod_next_s[N-1:0];
                    ca_nxt_s    = |prod_next_s[2*N-1:N];
                    ov_nxt_s    = |prod_next_s[2*N-1:N];
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result/flag registers: updated only on completion, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= {N{1'b0}};
            z_r    <= 1'b0;
            neg_r  <= 1'b0;
            ca_r   <= 1'b0;
            o_r    <= 1'b0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= upd_s;
            if (upd_s) begin
                out_r <= res_nxt_s;
                z_r   <= (res_nxt_s == {N{1'b0}});
                neg_r <= res_nxt_s[N-1];
                ca_r  <= ca_nxt_s;
                o_r   <= ov_nxt_s;
                err_r <= err_nxt_s;
            end
        end
    end

    alu_mul_seq #(.N(N)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .step      (step_s),
        .a         (A),
        .b         (B),
        .prod_next (prod_next_s),
        .last      (mul_last_s)
    );

    assign out  = out_r;
    assign Z    = z_r;
    assign Neg  = neg_r;
    assign Ca   = ca_r;
    assign O    = o_r;
    assign err  = err_r;
    assign done = done_r;
    assign busy = (state_r == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at N=4 with hand-computed expected values.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A, B, sel;
    logic [3:0] out;
    logic       Z, Neg, Ca, O, busy, done, err;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .sel   (sel),
        .out   (out),
        .Z     (Z),
        .Neg   (Neg),
        .Ca    (Ca),
        .O     (O),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output vector check: out, Z, Neg, Ca, O, err, done, busy.
    task automatic chk_all(input string tag, input logic [3:0] e_out, input logic e_z,
                           input logic e_neg, input logic e_ca, input logic e_o,
                           input logic e_err, input logic e_done, input logic e_busy);
        chk({tag, ".out"},  {4'h0, out},   {4'h0, e_out});
        chk({tag, ".Z"},    {7'h0, Z},     {7'h0, e_z});
        chk({tag, ".Neg"},  {7'h0, Neg},   {7'h0, e_neg});
        chk({tag, ".Ca"},   {7'h0, Ca},    {7'h0, e_ca});
        chk({tag, ".O"},    {7'h0, O},     {7'h0, e_o});
        chk({tag, ".err"},  {7'h0, err},   {7'h0, e_err});
        chk({tag, ".done"}, {7'h0, done},  {7'h0, e_done});
        chk({tag, ".busy"}, {7'h0, busy},  {7'h0, e_busy});
    endtask

    // Apply one op at the falling edge, let it be taken, sample just after.
    task automatic issue(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        sel   = s;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        A     = 4'b0000;
        B     = 4'b0000;
        sel   = 4'b0000;

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 3 + (-3): wraps to zero with carry.
        issue(4'b0000, 4'b0011, 4'b1101);
        chk_all("add_zero", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;
        chk_all("add_hold", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADD 7 + 1: signed overflow.
        issue(4'b0000, 4'b0111, 4'b0001);
        chk_all("add_ovf", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b0;

        // SUB 7 - (-3) = 10 -> 1010, overflow, borrow.
        issue(4'b0001, 4'b0111, 4'b1101);
        chk_all("sub_ovf", 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b0;

        // SUB equal operands: zero, no borrow.
        issue(4'b0001, 4'b0101, 4'b0101);
        chk_all("sub_eq", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;

        // MUL 7 * 3 = 21 -> low 0101, high nonzero; start during busy ignored.
        issue(4'b1000, 4'b0111, 4'b0011);
        chk({"mul_busy1"}, {7'h0, busy}, 8'h01);
        chk({"mul_nodone1"}, {7'h0, done}, 8'h00);
        start = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            if (i == 2) begin
                start = 1'b1;
                sel   = 4'b0000;
                A     = 4'b0001;
                B     = 4'b0001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("mul_busy%0d", i), {7'h0, busy}, 8'h01);
            chk($sformatf("mul_nodone%0d", i), {7'h0, done}, 8'h00);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk_all("mul_done", 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_all("mul_hold", 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // SRA then SLL back to back, the second taken in the first's done cycle.
        issue(4'b0111, 4'b1000, 4'b0010);
        chk_all("sra", 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sel = 4'b0101;
        A   = 4'b1001;
        B   = 4'b0001;
        @(posedge clk); #1;
        chk_all("sll_b2b", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;

        // SRL by zero: unchanged, carry 0.
        issue(4'b0110, 4'b1011, 4'b0000);
        chk_all("srl_zero", 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;

        // Reserved select, then AND clears err.
        issue(4'b1111, 4'b1010, 4'b0101);
        chk_all("reserved", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        issue(4'b0010, 4'b1100, 4'b1010);
        chk_all("and", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;

        // Reset in the middle of a multiply.
        issue(4'b1000, 4'b0111, 4'b0011);
        chk({"mulrst_busy"}, {7'h0, busy}, 8'h01);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all("mul_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_nodone%0d", i), {7'h0, done}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0000, 4'b0101, 4'b0010);
        chk_all("add_after_rst", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;
        chk({"after_rst_idle"}, {7'h0, done}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, the operand and result width (N >= 2).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 The block SHALL have port start  input  1  request; operands and sel sampled when start=1 and busy=0.
REQ-005 The block SHALL have port A  input  N  operand A.
REQ-006 The block SHALL have port B  input  N  operand B; B[$clog2(N)-1:0] is the shift amount for shifts.
REQ-007 The block SHALL have port sel  input  4  operation select.
REQ-008 The block SHALL have port out  output  N  registered result.
REQ-009 The block SHALL have ports Z, Neg, Ca, O  output  1 each  registered zero, negative, carry, signed-overflow flags.
REQ-010 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when out and flags update.
REQ-012 The block SHALL have port err  output  1  registered; 1 when the completed op had a reserved sel.

Function
REQ-013 sel encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 MUL (unsigned); 1001-1111 reserved.
REQ-014 FSM states SHALL be IDLE and MUL; busy = (state == MUL).
REQ-015 A start accepted in cycle t for non-MUL sel SHALL update out, flags, err and pulse done in cycle t+1; state stays IDLE.
REQ-016 A start accepted in cycle t with sel=MUL SHALL enter MUL, run N shift-add iterations (one per cycle) with busy=1 for cycles t+1..t+N, and pulse done with busy=0 in cycle t+N+1.
REQ-017 start while busy=1 SHALL be ignored with no effect on operands, state or outputs.
REQ-018 start in the done cycle SHALL be accepted (back-to-back, no bubble).
REQ-019 out, flags and err SHALL hold their values between done pulses.
REQ-020 Z SHALL be (out == 0); Neg SHALL be out[N-1]; for every op.
REQ-021 ADD: Ca = carry out of A+B; O = signed overflow.
REQ-022 SUB: computed as A + ~B + 1; Ca = its carry out (1 iff A >= B unsigned); O = signed overflow.
REQ-023 AND/OR/XOR: Ca = 0, O = 0.
REQ-024 SLL/SRL/SRA: Ca = last bit shifted out, 0 when shift amount is 0; O = 0.
REQ-025 MUL: out = low N bits of the 2N-bit product; Ca = O = 1 iff high N bits are nonzero.
REQ-026 Reserved sel: out = 0, Z = 1, Neg = Ca = O = 0, err = 1, single-cycle latency; err = 0 for all legal ops.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, out = 0, Z = Neg = Ca = O = 0, busy = 0, done = 0, err = 0, independent of clk.
REQ-028 Reset during MUL SHALL abort it with no done pulse; first start after rst_n rises is accepted normally.

Structure
REQ-029 A shared package SHALL hold the sel opcode enum and the FSM state enum.
REQ-030 The shift-add multiplier datapath SHALL be one sub-module, alu_mul_seq, driven by the top FSM.

Verification (N=4)
REQ-031 ADD A=0011 B=1101 -> next cycle out=0000, Z=1, Ca=1, O=0, Neg=0, done=1.
REQ-032 SUB A=0111 B=1101 -> out=1010, Neg=1, O=1, Ca=0, Z=0.
REQ-033 MUL A=0111 B=0011 -> busy=1 for 4 cycles, done at t+5, out=0101, Ca=O=1; start pulsed during busy ignored.
REQ-034 SRA A=1000 B=0010 -> out=1110, Ca=0, Neg=1; SLL A=1001 B=0001 -> out=0010, Ca=1.
REQ-035 sel=1111 -> out=0000, Z=1, err=1; following AND A=1100 B=1010 -> out=1000, err=0.
REQ-036 rst_n low at MUL cycle t+2 -> all outputs 0 at once, no done; subsequent ADD completes in one cycle.
